// File: rtl/ay_bus_if.sv
// ay_bus_if: request port and BDIR/BC1/DA bus of the AY-3-891x host writer
interface ay_bus_if;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_addr;
   logic [7:0] req_data;
   logic [7:0] bus_da;
   logic       bus_bdir;
   logic       bus_bc1;
   modport master (input req_valid, req_addr, req_data, output req_ready, bus_da, bus_bdir, bus_bc1);
   modport slave (output req_valid, req_addr, req_data, input req_ready, bus_da, bus_bdir, bus_bc1);
endinterface

// File: rtl/ay_bus_writer.sv
// ay_bus_writer: queues PSG register writes and plays them out as LATCH/WRITE phases on the AY bus
module ay_bus_writer #(
   parameter logic [3:0] UPPER_ADDRESS = 4'b0000,
   parameter int PHASE_CYCLES = 1,
   parameter int GAP_CYCLES = 1,
   parameter int FIFO_DEPTH = 4,
   parameter bit SKIP_RELATCH = 1
) (
   input  logic clk,
   input  logic reset,
   ay_bus_if.master bus,
   output logic busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int MAXC = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
   localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] PH_LAST = CW'(PHASE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [1:0] IDLE = 2'd0, LATCH = 2'd1, WRITE = 2'd2, GAP = 2'd3;

   logic [11:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [1:0] state;
   logic [CW-1:0] cnt;
   logic [7:0] cur_data;
   logic [3:0] last_addr;
   logic last_valid, full, empty, push, pop, phase_end, next_ok, head_skip;
   logic [11:0] head;

   assign full = fifo_level == (AW + 1)'(FIFO_DEPTH);
   assign empty = fifo_level == '0;
   assign push = bus.req_valid && !full;
   assign bus.req_ready = !full;
   assign head = mem[rd_ptr];
   assign head_skip = SKIP_RELATCH && last_valid && last_addr == head[11:8];
   assign phase_end = cnt == PH_LAST;
   assign next_ok = state == IDLE || (state == WRITE && phase_end && GAP_CYCLES == 0) || (state == GAP && cnt == GAP_LAST);
   assign pop = next_ok && !empty;
   assign busy = !empty || state != IDLE;

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {bus.req_addr, bus.req_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) fifo_level <= fifo_level + 1'b1;
         else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      end
   end

   // DA is only reloaded on entry to LATCH or WRITE, so idle cycles keep showing write data
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         cur_data <= '0;
         last_addr <= '0;
         last_valid <= 1'b0;
         bus.bus_da <= '0;
         {bus.bus_bdir, bus.bus_bc1} <= 2'b00;
      end else if (pop) begin
         cnt <= '0;
         cur_data <= head[7:0];
         if (head_skip) begin
            state <= WRITE;
            bus.bus_da <= head[7:0];
            {bus.bus_bdir, bus.bus_bc1} <= 2'b10;
         end else begin
            state <= LATCH;
            bus.bus_da <= {UPPER_ADDRESS, head[11:8]};
            {bus.bus_bdir, bus.bus_bc1} <= 2'b11;
            last_addr <= head[11:8];
            last_valid <= 1'b1;
         end
      end else if (state == LATCH) begin
         cnt <= phase_end ? '0 : cnt + 1'b1;
         if (phase_end) begin
            state <= WRITE;
            bus.bus_da <= cur_data;
            {bus.bus_bdir, bus.bus_bc1} <= 2'b10;
         end
      end else if (state == WRITE) begin
         cnt <= phase_end ? '0 : cnt + 1'b1;
         if (phase_end) begin
            state <= (GAP_CYCLES > 0) ? GAP : IDLE;
            {bus.bus_bdir, bus.bus_bc1} <= 2'b00;
         end
      end else if (state == GAP) begin
         cnt <= (cnt == GAP_LAST) ? '0 : cnt + 1'b1;
         if (cnt == GAP_LAST) state <= IDLE;
      end
   end
endmodule

// File: tb/tb_ay_bus_writer.sv
// tb_ay_bus_writer: directed checks of four writer configurations (default, no skip, long phase, upper address)
module tb_ay_bus_writer;
   logic clk = 1'b0;
   logic rst;
   logic [3:0] vld;
   logic [3:0][3:0] ad;
   logic [3:0][7:0] dt;
   logic [3:0] rdy, busy_w;
   logic [3:0][2:0] lvl;
   logic [3:0][10:0] obs;
   logic [11:0] rq [8];
   logic [10:0] ex [16];
   logic [11:0] wq [$];
   logic [3:0] lat0;
   int passed = 0, total = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : gen_dut
      ay_bus_if bi ();
      assign bi.req_valid = vld[g];
      assign bi.req_addr = ad[g];
      assign bi.req_data = dt[g];
      assign rdy[g] = bi.req_ready;
      assign obs[g] = {busy_w[g], bi.bus_bdir, bi.bus_bc1, bi.bus_da};
      ay_bus_writer #(
         .UPPER_ADDRESS(g == 3 ? 4'hA : 4'h0),
         .PHASE_CYCLES(g == 2 ? 3 : 1),
         .GAP_CYCLES(g == 2 ? 0 : 1),
         .FIFO_DEPTH(4),
         .SKIP_RELATCH(g == 1 ? 1'b0 : 1'b1)
      ) u_dut (
         .clk(clk),
         .reset(rst),
         .bus(bi.master),
         .busy(busy_w[g]),
         .fifo_level(lvl[g])
      );
   end

   // Collects {latched register, data} for every WRITE cycle of instance 0
   always @(negedge clk) begin
      if (obs[0][9:8] == 2'b11) lat0 = obs[0][3:0];
      else if (obs[0][9:8] == 2'b10) wq.push_back({lat0, obs[0][7:0]});
   end

   function automatic logic [10:0] e(input logic b, input logic [1:0] p, input logic [7:0] d);
      return {b, p, d};
   endfunction

   // Entered at a negedge: drives rq[0..nreq-1] on consecutive edges and checks ex[] from the negedge after the first edge
   task automatic play(input int k, input int nreq, input int nexp, input string name);
      vld[k] = 1'b1;
      ad[k] = rq[0][11:8];
      dt[k] = rq[0][7:0];
      for (int j = 0; j < nexp; j++) begin
         @(negedge clk);
         if (j + 1 < nreq) begin
            ad[k] = rq[j+1][11:8];
            dt[k] = rq[j+1][7:0];
         end else vld[k] = 1'b0;
         total++;
         if (obs[k] !== ex[j]) $display("FAIL %s[%0d]: got busy/bus/da=%h expected %h", name, j, obs[k], ex[j]);
         else passed++;
      end
   endtask

   task automatic test_reset;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (obs[k] !== 11'h000) $display("FAIL reset_outputs[%0d]: got %h expected 000", k, obs[k]);
         else passed++;
      end
      total++;
      if (lvl[0] !== 3'd0) $display("FAIL reset_level: got %0d expected 0", lvl[0]);
      else passed++;
      total++;
      if (rdy[0] !== 1'b1) $display("FAIL reset_ready: got %b expected 1", rdy[0]);
      else passed++;
   endtask

   task automatic test_single;
      rq[0] = {4'd7, 8'h38};
      ex[0] = e(1'b1, 2'b00, 8'h00);
      ex[1] = e(1'b1, 2'b11, 8'h07);
      ex[2] = e(1'b1, 2'b10, 8'h38);
      ex[3] = e(1'b1, 2'b00, 8'h38);
      ex[4] = e(1'b0, 2'b00, 8'h38);
      play(0, 1, 5, "single");
   endtask

   task automatic test_skip_relatch;
      rq[0] = {4'd0, 8'h55};
      rq[1] = {4'd0, 8'hAA};
      ex[0] = e(1'b1, 2'b00, 8'h38);
      ex[1] = e(1'b1, 2'b11, 8'h00);
      ex[2] = e(1'b1, 2'b10, 8'h55);
      ex[3] = e(1'b1, 2'b00, 8'h55);
      ex[4] = e(1'b1, 2'b10, 8'hAA);
      ex[5] = e(1'b1, 2'b00, 8'hAA);
      ex[6] = e(1'b0, 2'b00, 8'hAA);
      play(0, 2, 7, "skip");
   endtask

   task automatic test_no_skip;
      rq[0] = {4'd0, 8'h55};
      rq[1] = {4'd0, 8'hAA};
      ex[0] = e(1'b1, 2'b00, 8'h00);
      ex[1] = e(1'b1, 2'b11, 8'h00);
      ex[2] = e(1'b1, 2'b10, 8'h55);
      ex[3] = e(1'b1, 2'b00, 8'h55);
      ex[4] = e(1'b1, 2'b11, 8'h00);
      ex[5] = e(1'b1, 2'b10, 8'hAA);
      ex[6] = e(1'b1, 2'b00, 8'hAA);
      ex[7] = e(1'b0, 2'b00, 8'hAA);
      play(1, 2, 8, "no_skip");
   endtask

   task automatic test_back_to_back;
      int i = 0, n = 0;
      wq.delete();
      while (i < 6 && n < 50) begin
         vld[0] = 1'b1;
         ad[0] = 4'(i + 1);
         dt[0] = 8'h10 + 8'(i);
         if (rdy[0]) i++;
         @(negedge clk);
         n++;
      end
      vld[0] = 1'b0;
      total++;
      if (i != 6) $display("FAIL b2b_accepted: got %0d expected 6", i);
      else passed++;
      total++;
      if (lvl[0] !== 3'd4) $display("FAIL b2b_level_full: got %0d expected 4", lvl[0]);
      else passed++;
      total++;
      if (rdy[0] !== 1'b0) $display("FAIL b2b_ready_full: got %b expected 0", rdy[0]);
      else passed++;
      while (busy_w[0] && n < 120) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (busy_w[0] !== 1'b0) $display("FAIL b2b_drain: busy still %b after %0d cycles", busy_w[0], n);
      else passed++;
      total++;
      if (wq.size() != 6) $display("FAIL b2b_count: got %0d writes expected 6", wq.size());
      else passed++;
      for (int j = 0; j < 6; j++) begin
         total++;
         if (j >= wq.size()) $display("FAIL b2b_write[%0d]: missing expected %h", j, {4'(j + 1), 8'h10 + 8'(j)});
         else if (wq[j] !== {4'(j + 1), 8'h10 + 8'(j)}) $display("FAIL b2b_write[%0d]: got %h expected %h", j, wq[j], {4'(j + 1), 8'h10 + 8'(j)});
         else passed++;
      end
   endtask

   task automatic test_long_phase;
      rq[0] = {4'd13, 8'h0E};
      ex[0] = e(1'b1, 2'b00, 8'h00);
      for (int j = 1; j <= 3; j++) ex[j] = e(1'b1, 2'b11, 8'h0D);
      for (int j = 4; j <= 6; j++) ex[j] = e(1'b1, 2'b10, 8'h0E);
      ex[7] = e(1'b0, 2'b00, 8'h0E);
      play(2, 1, 8, "long_phase");
   endtask

   task automatic test_upper_address;
      rq[0] = {4'd2, 8'h11};
      ex[0] = e(1'b1, 2'b00, 8'h00);
      ex[1] = e(1'b1, 2'b11, 8'hA2);
      ex[2] = e(1'b1, 2'b10, 8'h11);
      ex[3] = e(1'b1, 2'b00, 8'h11);
      ex[4] = e(1'b0, 2'b00, 8'h11);
      play(3, 1, 5, "upper");
   endtask

   task automatic test_reset_mid_write;
      rq[0] = {4'd5, 8'h77};
      rq[1] = {4'd6, 8'h88};
      rq[2] = {4'd7, 8'h99};
      ex[0] = e(1'b1, 2'b00, 8'h15);
      ex[1] = e(1'b1, 2'b11, 8'h05);
      ex[2] = e(1'b1, 2'b10, 8'h77);
      play(0, 3, 3, "pre_reset");
      total++;
      if (lvl[0] !== 3'd2) $display("FAIL pre_reset_level: got %0d expected 2", lvl[0]);
      else passed++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (obs[0] !== 11'h000) $display("FAIL midreset_outputs: got %h expected 000", obs[0]);
      else passed++;
      total++;
      if (lvl[0] !== 3'd0) $display("FAIL midreset_level: got %0d expected 0", lvl[0]);
      else passed++;
      total++;
      if (rdy[0] !== 1'b1) $display("FAIL midreset_ready: got %b expected 1", rdy[0]);
      else passed++;
      rq[0] = {4'd5, 8'hAA};
      ex[0] = e(1'b1, 2'b00, 8'h00);
      ex[1] = e(1'b1, 2'b11, 8'h05);
      ex[2] = e(1'b1, 2'b10, 8'hAA);
      ex[3] = e(1'b1, 2'b00, 8'hAA);
      ex[4] = e(1'b0, 2'b00, 8'hAA);
      play(0, 1, 5, "post_reset");
   endtask

   initial begin
      rst = 1'b1;
      vld = '0;
      ad = '0;
      dt = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_single();
      test_skip_relatch();
      test_no_skip();
      test_back_to_back();
      test_long_phase();
      test_upper_address();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
